fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Output reorder buffer placed after the final butterfly stage of the radix-2 FFT pipeline.
- It consumes the stage stream (en/addr/data), in which the sample at stream address k is FFT bin bitrev(k).
- Each frame is written into one half of a ping-pong buffer at the bit-reversed address.
- Full frames are read out in natural bin order on a valid/ready stream, so downstream consumers can apply backpressure; the FFT pipeline itself cannot be stalled.

Parameters:
- FFT_STG, 7, log2 of frame length N (N = 2^FFT_STG points).
- CPLX_WIDTH, 32, complex sample width (re in upper half, im in lower half); passed through unchanged.

Ports:
- iclk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ien  in  1  input sample valid; no backpressure possible.
- iaddr  in  FFT_STG  stream address within frame (bit-reversed bin index).
- idata  in  CPLX_WIDTH  input sample.
- ovalid  out  1  output sample valid.
- oready  in  1  downstream accepts when ovalid&oready.
- odata  out  CPLX_WIDTH  natural-order output sample.
- oidx  out  FFT_STG  natural bin index of odata.
- olast  out  1  high with bin N-1.
- ovf  out  1  one-cycle pulse when an incoming frame is dropped.

Behaviour:
- Reset (async, rst_n=0):
  - ovalid=0, odata=0, oidx=0, olast=0, ovf=0.
  - Both bank-full flags cleared; wr_bank=0; rd_bank=0; write FSM in IDLE.
  - Reset mid-frame discards all buffered data; no partial output after release.
- Storage: 2 banks x N words, synchronous write, registered read (1-cycle latency).
- Write FSM states and transitions:
  - IDLE: ien&&iaddr==0 starts a frame.
    - If bank wr_bank is empty: write, go to FILL.
    - Else: go to DROP and pulse ovf on the next edge.
  - IDLE with ien&&iaddr!=0 is a mid-frame join; it is ignored and stays IDLE with no ovf.
  - FILL: each ien writes idata to bank[wr_bank][bitrev(iaddr)].
    - ien&&iaddr==N-1 sets full[wr_bank], toggles wr_bank, returns to IDLE.
    - Cycles with ien=0 are gaps; they are tolerated and state holds.
    - ien&&iaddr==0 while in FILL: the current partial frame is abandoned (not marked full), and the new frame starts in the same bank.
  - DROP: data is discarded; ien&&iaddr==N-1 returns to IDLE.
- Read side:
  - Active when full[rd_bank]=1.
  - Read counter rcnt 0..N-1 addresses bank[rd_bank][rcnt] in natural order.
  - A one-entry prefetch register plus the output register hide the RAM latency, so a continuous oready=1 gives one sample per cycle with no bubbles.
- Output register:
  - odata/oidx/olast hold stable while ovalid&&!oready.
  - Advances only on handshake.
- End of bank:
  - Handshake with olast=1 clears full[rd_bank] and toggles rd_bank.
  - If the other bank is already full, the next frame's bin 0 follows on the next cycle with no gap.
- Latency: the last write of a frame at edge T gives ovalid=1 at edge T+2 at the earliest (bank idle, output empty).
- Simultaneous events:
  - If a frame start targets the bank whose olast handshake occurs on the same edge, the bank counts as empty and the frame is accepted.
  - Write and read to the same bank in the same cycle cannot happen, by construction of the full flags.
- Wrap-around: rcnt and the write address wrap modulo N. wr_bank and rd_bank toggle independently.
- ovf is exactly one cycle per dropped frame.

Test Plan:
- FFT_STG=3: one frame, iaddr 0..7 with idata=k, oready=1 → odata 0,4,2,6,1,5,3,7; oidx 0..7; olast at oidx 7; first ovalid 2 cycles after iaddr=7 write.
- Three back-to-back frames (data k, 8+k, 16+k), oready=0 until all input is done → frames 1 and 2 buffered, frame 3 dropped with a single ovf pulse. Releasing oready then gives 16 outputs from frames 1 and 2 with no gap at the bank switch.
- Random oready toggling during a frame → odata/oidx stable whenever ovalid&&!oready; no sample lost or duplicated; order matches the bitrev sequence.
- Input starts at iaddr=5 (mid-frame), then a full frame → first 3 samples ignored, no ovf, only the full frame is output.
- rst_n pulled low while ovalid=1 at oidx 3 → all outputs 0 immediately; after release no output until a new complete frame arrives.
- Frame start at iaddr=0 on the same edge as the olast handshake of the only free candidate bank → frame accepted, no ovf, output correct.

Source files
------------

// File: rtl/fft_bitrev_reorder_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : fft_bitrev_reorder_if                                          |
// | Purpose  : Bundles the FFT stage input stream and the natural-order       |
// |            valid/ready output stream of the bit-reverse reorder buffer.   |
// | Signals  : ien/iaddr/idata  - stage stream into the buffer (no stall)     |
// |            ovalid/oready    - output handshake                            |
// |            odata/oidx/olast - natural-order sample, bin index, last bin   |
// |            ovf              - one-cycle pulse per dropped frame           |
// | Modports : master - stream source / output sink                           |
// |            slave  - the reorder buffer itself                             |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
interface fft_bitrev_reorder_if #(
  parameter int FFT_STG    = 7,
  parameter int CPLX_WIDTH = 32
) ();
  logic                  ien;
  logic [FFT_STG-1:0]    iaddr;
  logic [CPLX_WIDTH-1:0] idata;
  logic                  ovalid;
  logic                  oready;
  logic [CPLX_WIDTH-1:0] odata;
  logic [FFT_STG-1:0]    oidx;
  logic                  olast;
  logic                  ovf;

  modport master (
    output ien, iaddr, idata, oready,
    input  ovalid, odata, oidx, olast, ovf
  );

  modport slave (
    input  ien, iaddr, idata, oready,
    output ovalid, odata, oidx, olast, ovf
  );
endinterface
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : fft_bitrev_reorder                                             |
// | Purpose  : Ping-pong reorder buffer after the last radix-2 butterfly      |
// |            stage. Each frame is written at bit-reversed addresses into    |
// |            one bank; full banks are streamed out in natural bin order     |
// |            on a valid/ready interface. Frames arriving while the target   |
// |            bank is still occupied are dropped and flagged on ovf.         |
// | Ports    : iclk  - clock, rising edge                                     |
// |            rst_n - asynchronous active-low reset                          |
// |            bus   - slave side of fft_bitrev_reorder_if                    |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module fft_bitrev_reorder #(
  parameter int FFT_STG    = 7,
  parameter int CPLX_WIDTH = 32
) (
  input  wire logic           iclk,
  input  wire logic           rst_n,
  fft_bitrev_reorder_if.slave bus
);

  localparam int                 N         = 1 << FFT_STG;
  localparam logic [FFT_STG-1:0] ADDR_LAST = {FFT_STG{1'b1}};
  localparam logic [FFT_STG-1:0] ADDR_ONE  = {{(FFT_STG-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_state_t             wr_state_q, wr_state_d;
  logic                  wr_bank_q,  wr_bank_d;
  logic [1:0]            full_q,     full_d;
  logic                  ovf_q,      ovf_d;

  logic                  rd_bank_q,  rd_bank_d;   // bank currently presented on the output
  logic                  iss_bank_q, iss_bank_d;  // bank the read counter is walking
  logic [FFT_STG-1:0]    rcnt_q,     rcnt_d;

  logic                  pf_valid_q, pf_valid_d;
  logic [FFT_STG-1:0]    pf_idx_q,   pf_idx_d;
  logic [CPLX_WIDTH-1:0] pf_data_q;               // registered RAM read port

  logic                  out_valid_q, out_valid_d;
  logic [CPLX_WIDTH-1:0] out_data_q,  out_data_d;
  logic [FFT_STG-1:0]    out_idx_q,   out_idx_d;
  logic                  out_last_q,  out_last_d;

  logic [CPLX_WIDTH-1:0] mem_q [0:2*N-1];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [FFT_STG-1:0] w_bitrev;
  logic               w_start;
  logic               w_end;
  logic               w_pop;
  logic               w_rd_free;
  logic               w_wr_bank_free;
  logic               w_we;
  logic               w_set_full;
  logic               w_out_load;
  logic               w_issue;

  for (genvar gi = 0; gi < FFT_STG; gi++) begin : g_bitrev
    assign w_bitrev[gi] = bus.iaddr[FFT_STG-1-gi];
  end

  assign w_start   = bus.ien && (bus.iaddr == '0);
  assign w_end     = bus.ien && (bus.iaddr == ADDR_LAST);
  assign w_pop     = out_valid_q && bus.oready;
  assign w_rd_free = w_pop && out_last_q;

  // A bank whose last sample leaves on this very edge is already free for a
  // new frame starting on the same edge.
  assign w_wr_bank_free = !full_q[wr_bank_q] ||
                          (w_rd_free && (rd_bank_q == wr_bank_q));

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    ovf_d      = 1'b0;
    w_we       = 1'b0;
    w_set_full = 1'b0;

    case (wr_state_q)
      WR_IDLE: begin
        // Samples with a nonzero address here belong to a frame we joined
        // mid-way; they are silently ignored.
        if (w_start) begin
          if (w_wr_bank_free) begin
            w_we       = 1'b1;
            wr_state_d = WR_FILL;
          end else begin
            ovf_d      = 1'b1;
            wr_state_d = WR_DROP;
          end
        end
      end

      WR_FILL: begin
        // An address-0 sample in FILL restarts the frame in the same bank;
        // simply writing it over the partial frame achieves that.
        if (bus.ien) begin
          w_we = 1'b1;
          if (w_end) begin
            w_set_full = 1'b1;
            wr_bank_d  = ~wr_bank_q;
            wr_state_d = WR_IDLE;
          end
        end
      end

      WR_DROP: begin
        if (w_end) begin
          wr_state_d = WR_IDLE;
        end
      end

      default: begin
        wr_state_d = WR_IDLE;
      end
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (w_rd_free) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (w_set_full) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: RAM read register acts as the prefetch slot in front of the
  // output register. A read is issued only when the prefetch slot is empty or
  // drains into the output on the same edge, so nothing is ever overwritten.
  // The issue pointer runs ahead of rd_bank_q so the next bank's bin 0 is
  // already prefetched when the current bank's last bin is handed over.
  // ---------------------------------------------------------------------------
  assign w_out_load = !out_valid_q || w_pop;
  assign w_issue    = full_q[iss_bank_q] && (!pf_valid_q || w_out_load);

  always_comb begin
    rcnt_d      = rcnt_q;
    iss_bank_d  = iss_bank_q;
    pf_valid_d  = pf_valid_q;
    pf_idx_d    = pf_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    rd_bank_d   = rd_bank_q;

    if (w_issue) begin
      rcnt_d     = rcnt_q + ADDR_ONE;
      pf_valid_d = 1'b1;
      pf_idx_d   = rcnt_q;
      if (rcnt_q == ADDR_LAST) begin
        iss_bank_d = ~iss_bank_q;
      end
    end else if (w_out_load) begin
      pf_valid_d = 1'b0;
    end

    if (w_out_load) begin
      out_valid_d = pf_valid_q;
      if (pf_valid_q) begin
        out_data_d = pf_data_q;
        out_idx_d  = pf_idx_q;
        out_last_d = (pf_idx_q == ADDR_LAST);
      end else begin
        out_last_d = 1'b0;
      end
    end

    if (w_rd_free) begin
      rd_bank_d = ~rd_bank_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: synchronous write, registered read
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk) begin
    if (w_we) begin
      mem_q[{wr_bank_q, w_bitrev}] <= bus.idata;
    end
    if (w_issue) begin
      pf_data_q <= mem_q[{iss_bank_q, rcnt_q}];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q  <= WR_IDLE;
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      ovf_q       <= 1'b0;
      rd_bank_q   <= 1'b0;
      iss_bank_q  <= 1'b0;
      rcnt_q      <= '0;
      pf_valid_q  <= 1'b0;
      pf_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      rd_bank_q   <= rd_bank_d;
      iss_bank_q  <= iss_bank_d;
      rcnt_q      <= rcnt_d;
      pf_valid_q  <= pf_valid_d;
      pf_idx_q    <= pf_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.ovalid = out_valid_q;
  assign bus.odata  = out_data_q;
  assign bus.oidx   = out_idx_q;
  assign bus.olast  = out_last_q;
  assign bus.ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_fft_bitrev_reorder                                          |
// | Purpose  : Self-checking bench for fft_bitrev_reorder (N = 8).            |
// |            Expected output is derived from the frames sent: natural bin   |
// |            j of a frame equals the sample sent at stream address bitrev(j)|
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_fft_bitrev_reorder;

  localparam int STG = 3;
  localparam int W   = 32;
  localparam int N   = 1 << STG;

  typedef logic [W-1:0] frame_t [N];
  typedef struct {
    logic [W-1:0] data;
    int           idx;
    logic         last;
    int           cyc;
  } hs_t;

  logic iclk = 1'b0;
  logic rst_n;

  always #5 iclk = ~iclk;

  fft_bitrev_reorder_if #(.FFT_STG(STG), .CPLX_WIDTH(W)) bus ();

  fft_bitrev_reorder #(.FFT_STG(STG), .CPLX_WIDTH(W)) dut (
    .iclk  (iclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           ovf_cnt = 0;
  int           stab_viol = 0;
  hs_t          got[$];
  logic [W-1:0] exp_q[$];

  // ---------------- recording monitor (no checking here) ----------------
  initial forever begin
    @(posedge iclk);
    cyc++;
  end

  initial begin : monitor
    logic         prev_hold;
    logic [W-1:0] prev_data;
    logic [STG-1:0] prev_idx;
    logic         prev_last;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_idx  = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge iclk);
      if (rst_n !== 1'b1) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && (bus.ovalid !== 1'b1 || bus.odata !== prev_data ||
                          bus.oidx !== prev_idx || bus.olast !== prev_last))
          stab_viol++;
        if (bus.ovf === 1'b1) ovf_cnt++;
        if (bus.ovalid === 1'b1 && bus.oready === 1'b1)
          got.push_back('{data: bus.odata, idx: int'(bus.oidx), last: bus.olast, cyc: cyc});
        prev_hold = (bus.ovalid === 1'b1) && (bus.oready !== 1'b1);
        prev_data = bus.odata;
        prev_idx  = bus.oidx;
        prev_last = bus.olast;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int bitrev_ref(input int x);
    int r;
    r = 0;
    for (int b = 0; b < STG; b++) r = (r * 2) + ((x >> b) & 1);
    return r;
  endfunction

  function automatic void expect_frame(input frame_t f);
    for (int j = 0; j < N; j++) exp_q.push_back(f[bitrev_ref(j)]);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_frame(input frame_t f, input int gap_pct);
    for (int k = 0; k < N; k++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        bus.ien = 1'b0;
        @(posedge iclk); #1;
      end
      bus.ien   = 1'b1;
      bus.iaddr = STG'(k);
      bus.idata = f[k];
      @(posedge iclk); #1;
    end
    bus.ien = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) @(posedge iclk);
    @(negedge iclk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    n_vec++;
    if (bus.ovalid !== 1'b0 || bus.olast !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ovalid=%b olast=%b ovf=%b, expected 0 0 0", bus.ovalid, bus.olast, bus.ovf);
    end
    n_vec++;
    if (bus.odata !== '0 || bus.oidx !== '0) begin
      n_err++;
      $display("FAIL reset_data: odata=%h oidx=%0d, expected 0 0", bus.odata, bus.oidx);
    end
    rst_n = 1'b1;
    @(negedge iclk);
  endtask

  task automatic test_single_frame();
    frame_t f;
    int ovf0;
    got.delete(); exp_q.delete(); ovf0 = ovf_cnt;
    bus.oready = 1'b1;
    for (int k = 0; k < N; k++) f[k] = W'(k);
    expect_frame(f);
    send_frame(f, 0);  // returns 1 ns after the edge that wrote address N-1
    for (int d = 0; d < 3; d++) begin
      @(negedge iclk);
      n_vec++;
      if (bus.ovalid !== (d == 2)) begin
        n_err++;
        $display("FAIL single_latency: %0d edges after last write ovalid=%b, expected %b", d, bus.ovalid, (d == 2));
      end
    end
    wait_got(N, 50);
    repeat (5) @(posedge iclk);
    n_vec++;
    if (got.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL single_count: got %0d outputs, expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vec++;
      if (got[i].data !== exp_q[i] || got[i].idx !== i % N || got[i].last !== (i % N == N - 1)) begin
        n_err++;
        $display("FAIL single_out[%0d]: data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                 i, got[i].data, got[i].idx, got[i].last, exp_q[i], i % N, (i % N == N - 1));
      end
    end
    n_vec++;
    if (ovf_cnt - ovf0 !== 0) begin
      n_err++;
      $display("FAIL single_ovf: %0d ovf pulses, expected 0", ovf_cnt - ovf0);
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2, f3;
    int ovf0;
    bit gap_ok;
    got.delete(); exp_q.delete(); ovf0 = ovf_cnt;
    @(posedge iclk); #1;
    bus.oready = 1'b0;
    for (int k = 0; k < N; k++) begin
      f1[k] = W'(k); f2[k] = W'(8 + k); f3[k] = W'(16 + k);
    end
    expect_frame(f1);
    expect_frame(f2);
    send_frame(f1, 0);
    send_frame(f2, 0);
    send_frame(f3, 0);
    repeat (6) @(posedge iclk);
    @(negedge iclk);
    n_vec++;
    if (ovf_cnt - ovf0 !== 1) begin
      n_err++;
      $display("FAIL b2b_ovf: %0d ovf pulse cycles, expected 1", ovf_cnt - ovf0);
    end
    n_vec++;
    if (got.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_held: %0d outputs while oready=0, expected 0", got.size());
    end
    @(posedge iclk); #1;
    bus.oready = 1'b1;
    wait_got(2 * N, 60);
    repeat (5) @(posedge iclk);
    n_vec++;
    if (got.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_count: got %0d outputs, expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vec++;
      if (got[i].data !== exp_q[i] || got[i].idx !== i % N || got[i].last !== (i % N == N - 1)) begin
        n_err++;
        $display("FAIL b2b_out[%0d]: data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                 i, got[i].data, got[i].idx, got[i].last, exp_q[i], i % N, (i % N == N - 1));
      end
    end
    gap_ok = 1'b1;
    for (int i = 1; i < got.size(); i++) if (got[i].cyc != got[i-1].cyc + 1) gap_ok = 1'b0;
    n_vec++;
    if (gap_ok !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_nogap: output stream had bubbles, expected one sample per cycle");
    end
  endtask

  task automatic test_random_backpressure();
    frame_t fa, fb;
    int ovf0;
    got.delete(); exp_q.delete(); ovf0 = ovf_cnt;
    for (int k = 0; k < N; k++) begin
      fa[k] = W'($urandom); fb[k] = W'($urandom);
    end
    expect_frame(fa);
    expect_frame(fb);
    fork
      begin
        send_frame(fa, 30);
        send_frame(fb, 30);
      end
      begin
        repeat (80) begin
          @(posedge iclk); #1;
          bus.oready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.oready = 1'b1;
    wait_got(2 * N, 100);
    repeat (5) @(posedge iclk);
    n_vec++;
    if (got.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL rand_count: got %0d outputs, expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vec++;
      if (got[i].data !== exp_q[i] || got[i].idx !== i % N || got[i].last !== (i % N == N - 1)) begin
        n_err++;
        $display("FAIL rand_out[%0d]: data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                 i, got[i].data, got[i].idx, got[i].last, exp_q[i], i % N, (i % N == N - 1));
      end
    end
    n_vec++;
    if (stab_viol !== 0) begin
      n_err++;
      $display("FAIL rand_hold: %0d cycles where output changed while stalled, expected 0", stab_viol);
    end
    n_vec++;
    if (ovf_cnt - ovf0 !== 0) begin
      n_err++;
      $display("FAIL rand_ovf: %0d ovf pulses, expected 0", ovf_cnt - ovf0);
    end
  endtask

  task automatic test_mid_frame_join();
    frame_t f;
    int ovf0;
    got.delete(); exp_q.delete(); ovf0 = ovf_cnt;
    bus.oready = 1'b1;
    @(posedge iclk); #1;
    for (int k = 5; k < N; k++) begin
      bus.ien = 1'b1; bus.iaddr = STG'(k); bus.idata = W'(100 + k);
      @(posedge iclk); #1;
    end
    for (int k = 0; k < N; k++) f[k] = W'(200 + k);
    expect_frame(f);
    send_frame(f, 0);
    wait_got(N, 50);
    repeat (10) @(posedge iclk);
    n_vec++;
    if (got.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL join_count: got %0d outputs, expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vec++;
      if (got[i].data !== exp_q[i] || got[i].idx !== i % N || got[i].last !== (i % N == N - 1)) begin
        n_err++;
        $display("FAIL join_out[%0d]: data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                 i, got[i].data, got[i].idx, got[i].last, exp_q[i], i % N, (i % N == N - 1));
      end
    end
    n_vec++;
    if (ovf_cnt - ovf0 !== 0) begin
      n_err++;
      $display("FAIL join_ovf: %0d ovf pulses, expected 0", ovf_cnt - ovf0);
    end
  endtask

  task automatic test_reset_mid_output();
    frame_t f, g;
    bit found;
    got.delete(); exp_q.delete();
    bus.oready = 1'b1;
    for (int k = 0; k < N; k++) begin
      f[k] = W'(300 + k); g[k] = W'($urandom);
    end
    send_frame(f, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge iclk);
      if (bus.ovalid === 1'b1 && bus.oidx === STG'(3)) found = 1'b1;
    end
    n_vec++;
    if (found !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_reach: never saw ovalid at oidx 3, expected within 40 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.ovalid !== 1'b0 || bus.odata !== '0 || bus.oidx !== '0 || bus.olast !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_clear: ovalid=%b odata=%h oidx=%0d olast=%b ovf=%b, expected all 0",
               bus.ovalid, bus.odata, bus.oidx, bus.olast, bus.ovf);
    end
    @(negedge iclk);
    rst_n = 1'b1;
    got.delete();
    repeat (20) @(posedge iclk);
    @(negedge iclk);
    n_vec++;
    if (got.size() !== 0 || bus.ovalid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_residue: %0d outputs ovalid=%b after reset, expected 0 0", got.size(), bus.ovalid);
    end
    expect_frame(g);
    send_frame(g, 0);
    wait_got(N, 50);
    repeat (5) @(posedge iclk);
    n_vec++;
    if (got.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL rstmid_count: got %0d outputs, expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vec++;
      if (got[i].data !== exp_q[i] || got[i].idx !== i % N || got[i].last !== (i % N == N - 1)) begin
        n_err++;
        $display("FAIL rstmid_out[%0d]: data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                 i, got[i].data, got[i].idx, got[i].last, exp_q[i], i % N, (i % N == N - 1));
      end
    end
  endtask

  task automatic test_same_edge_release();
    frame_t fa, fb, fc;
    int ovf0;
    bit found;
    rst_n = 1'b0;
    @(negedge iclk);
    rst_n = 1'b1;
    got.delete(); exp_q.delete(); ovf0 = ovf_cnt;
    bus.oready = 1'b0;
    for (int k = 0; k < N; k++) begin
      fa[k] = W'(500 + k); fb[k] = W'(600 + k); fc[k] = W'($urandom);
    end
    expect_frame(fa);
    expect_frame(fb);
    expect_frame(fc);
    send_frame(fa, 0);
    send_frame(fb, 0);
    repeat (3) @(posedge iclk);
    #1 bus.oready = 1'b1;
    // Present address 0 of the next frame exactly when the first bank's last
    // bin is about to be accepted; both banks are full until that edge.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge iclk);
      if (bus.ovalid === 1'b1 && bus.olast === 1'b1) begin
        found = 1'b1;
        bus.ien = 1'b1; bus.iaddr = '0; bus.idata = fc[0];
      end
    end
    for (int k = 1; k < N; k++) begin
      @(posedge iclk); #1;
      bus.ien = 1'b1; bus.iaddr = STG'(k); bus.idata = fc[k];
    end
    @(posedge iclk); #1;
    bus.ien = 1'b0;
    n_vec++;
    if (found !== 1'b1) begin
      n_err++;
      $display("FAIL same_reach: never saw olast, expected within 40 cycles");
    end
    wait_got(3 * N, 80);
    repeat (5) @(posedge iclk);
    n_vec++;
    if (ovf_cnt - ovf0 !== 0) begin
      n_err++;
      $display("FAIL same_ovf: %0d ovf pulses, expected 0", ovf_cnt - ovf0);
    end
    n_vec++;
    if (got.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL same_count: got %0d outputs, expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vec++;
      if (got[i].data !== exp_q[i] || got[i].idx !== i % N || got[i].last !== (i % N == N - 1)) begin
        n_err++;
        $display("FAIL same_out[%0d]: data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                 i, got[i].data, got[i].idx, got[i].last, exp_q[i], i % N, (i % N == N - 1));
      end
    end
  endtask

  initial begin
    bus.ien    = 1'b0;
    bus.iaddr  = '0;
    bus.idata  = '0;
    bus.oready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_backpressure();
    test_mid_frame_join();
    test_reset_mid_output();
    test_same_edge_release();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
